// File: rtl/hart_dbg_ctl.sv
// hart_dbg_ctl: per-hart debug halt/resume controller.
// Every hart runs an independent RUNNING/HALTING/HALTED/RESUMING(/STEPPING)
// state machine; the only cross-hart logic is the four summary outputs.
// Optional feature macro: HART_DBG_STEP_EN (single-step via STEPPING state).
// With the macro undefined the step port is kept but ignored and a resume
// always returns the hart to RUNNING.

module hart_dbg_lane #(
    parameter int HALT_TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic halt_req,
    input  logic resume_req,
    input  logic core_halted,
    input  logic retire,
    input  logic step,
    input  logic err_clr,
    output logic debug,
    output logic halted,
    output logic running,
    output logic resume_ack,
    output logic halt_err
);

    // Counter is only meaningful when a timeout is configured; keep it one
    // bit wide otherwise so the logic stays legal and trivially small.
    localparam int CW = (HALT_TIMEOUT > 0) ? $clog2(HALT_TIMEOUT + 1) : 1;
    localparam bit TO_EN = (HALT_TIMEOUT > 0);
    // The counter holds the number of HALTING cycles already spent before
    // the current one, so the last allowed cycle sees HALT_TIMEOUT-1.
    localparam logic [CW-1:0] TO_LAST = CW'((HALT_TIMEOUT > 0) ? HALT_TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_HALTING   = 3'd1,
        ST_HALTED    = 3'd2,
        ST_RESUMING  = 3'd3,
        ST_STEPPING  = 3'd4
    } state_e;

    state_e        state;
    state_e        state_nxt;
    logic [CW-1:0] cnt;
    logic          to_hit;
    logic          step_q;

    // Timeout fires on the last permitted HALTING cycle if the core has not
    // parked; a core_halted in that same cycle still wins.
    assign to_hit = TO_EN && (state == ST_HALTING) && !core_halted && (cnt == TO_LAST);

    // State register; reset forces RUNNING from any state.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    // Next-state logic; halt wins in RUNNING/STEPPING, resume wins in HALTED
    // simply because each state only looks at the request it cares about.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (halt_req) state_nxt = ST_HALTING;
            end
            ST_HALTING: begin
                if (core_halted)  state_nxt = ST_HALTED;
                else if (to_hit)  state_nxt = ST_RUN;
            end
            ST_HALTED: begin
                if (resume_req) state_nxt = ST_RESUMING;
            end
            ST_RESUMING: begin
`ifdef HART_DBG_STEP_EN
                if (!core_halted) state_nxt = step_q ? ST_STEPPING : ST_RUN;
`else
                if (!core_halted) state_nxt = ST_RUN;
`endif
            end
`ifdef HART_DBG_STEP_EN
            ST_STEPPING: begin
                if (retire || halt_req) state_nxt = ST_HALTING;
            end
`endif
            default: state_nxt = ST_RUN;
        endcase
    end

    // Output decode purely from the state register (no input-to-output path).
    always_comb begin
        debug   = (state == ST_HALTING) || (state == ST_HALTED);
        halted  = (state == ST_HALTED);
        running = (state == ST_RUN);
    end

    // HALTING cycle counter: zero outside HALTING, saturating inside it.
    always_ff @(posedge clk) begin
        if (!rst_n)                               cnt <= '0;
        else if (state != ST_HALTING || to_hit)   cnt <= '0;
        else if (cnt != CNT_MAX)                  cnt <= cnt + CW'(1);
    end

`ifdef HART_DBG_STEP_EN
    // Capture dcsr.step at the moment the resume is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n)                               step_q <= 1'b0;
        else if (state == ST_HALTED && resume_req) step_q <= step;
    end
`else
    // Stepping is compiled out; the inputs are deliberately left unused.
    logic unused_step_inputs;
    assign unused_step_inputs = step ^ retire;
    assign step_q = 1'b0;
`endif

    // Resume acknowledge: one-cycle pulse registered off the RESUMING exit.
    always_ff @(posedge clk) begin
        if (!rst_n) resume_ack <= 1'b0;
        else        resume_ack <= (state == ST_RESUMING) && !core_halted;
    end

    // Sticky timeout flag; a same-cycle timeout beats err_clr.
    always_ff @(posedge clk) begin
        if (!rst_n)       halt_err <= 1'b0;
        else if (to_hit)  halt_err <= 1'b1;
        else if (err_clr) halt_err <= 1'b0;
    end

endmodule

module hart_dbg_ctl #(
    parameter int NHARTS       = 1,
    parameter int HALT_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NHARTS-1:0] halt_req,
    input  logic [NHARTS-1:0] resume_req,
    input  logic [NHARTS-1:0] core_halted,
    input  logic [NHARTS-1:0] retire,
    input  logic [NHARTS-1:0] step,
    input  logic [NHARTS-1:0] err_clr,
    output logic [NHARTS-1:0] debug,
    output logic [NHARTS-1:0] halted,
    output logic [NHARTS-1:0] running,
    output logic [NHARTS-1:0] resume_ack,
    output logic [NHARTS-1:0] halt_err,
    output logic              any_halted,
    output logic              all_halted,
    output logic              any_running,
    output logic              all_running
);

    // One fully independent controller per hart.
    for (genvar h = 0; h < NHARTS; h++) begin : g_hart
        hart_dbg_lane #(
            .HALT_TIMEOUT(HALT_TIMEOUT)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .halt_req   (halt_req[h]),
            .resume_req (resume_req[h]),
            .core_halted(core_halted[h]),
            .retire     (retire[h]),
            .step       (step[h]),
            .err_clr    (err_clr[h]),
            .debug      (debug[h]),
            .halted     (halted[h]),
            .running    (running[h]),
            .resume_ack (resume_ack[h]),
            .halt_err   (halt_err[h])
        );
    end

    // Summaries reduce the registered per-hart state flags.
    always_comb begin
        any_halted  = |halted;
        all_halted  = &halted;
        any_running = |running;
        all_running = &running;
    end

endmodule
